// File: rtl/midi_tx_arb.sv
// Round-robin whole-message arbiter sharing one midi_tx serializer between NUM_SRC sources.
// Optional running-status suppression is built when MIDI_TX_ARB_RUNNING_STATUS_EN is defined.
module midi_tx_arb #(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC*8-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [2:0]      last_grant;
  logic [WD_W-1:0] wd_cnt;

  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;
  logic       active;
  logic       drop;
  logic       xfer_ok;

  // First requester strictly after the previous grant, wrapping around.
  function automatic logic [2:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                         input logic [2:0] last);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last) + k) % NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!found && (i == idx) && req[i]) begin
          pick  = 3'(i);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == 3'(i)) begin
        g_valid = src_valid[i];
        g_last  = src_last[i];
        g_data  = src_data[8*i +: 8];
      end
    end
  end

  // The timeout cycle blocks the handshake even if the source reappears.
  assign active = (state == XFER) && !err_timeout;

`ifdef MIDI_TX_ARB_RUNNING_STATUS_EN
  logic [7:0] rs_status;

  // rs_status of zero never matches, since only 0x80-0xEF are candidates.
  assign drop = active && g_valid && (g_data >= 8'h80) && (g_data < 8'hF0) &&
                (g_data == rs_status);

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_status <= '0;
    end else if ((state == XFER) && err_timeout) begin
      rs_status <= '0;
    end else if (xfer_ok && !drop) begin
      if ((g_data >= 8'h80) && (g_data < 8'hF0)) begin
        rs_status <= g_data;
      end else if ((g_data >= 8'hF0) && (g_data < 8'hF8)) begin
        rs_status <= '0;
      end
    end
  end
`else
  assign drop = 1'b0;
`endif

  assign xfer_ok = active && g_valid && (drop || tx_ready);

  always_comb begin
    src_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    if (state == XFER) begin
      tx_data = g_data;
    end
    if (active) begin
      tx_valid = g_valid && !drop;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_id == 3'(i)) begin
          src_ready[i] = drop || tx_ready;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 3'(NUM_SRC - 1);
      grant_id    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          err_timeout <= 1'b0;
          wd_cnt      <= '0;
          if (|src_valid) begin
            grant_id <= rr_pick(src_valid, last_grant);
            busy     <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if (err_timeout) begin
            err_timeout <= 1'b0;
            last_grant  <= grant_id;
            busy        <= 1'b0;
            wd_cnt      <= '0;
            state       <= IDLE;
          end else if (xfer_ok) begin
            wd_cnt <= '0;
            if (g_last) begin
              last_grant <= grant_id;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else if (!g_valid) begin
            // Only a silent source ages the watchdog; tx_ready stalls hold it.
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
            end
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
